// File: rtl/mp_fifo_dat_vld_output.sv
// Multi-port FIFO with per-lane enqueue/dequeue, raw storage and valid-flag outputs.
// Optional high-water-mark output hwm_o is enabled by defining MP_FIFO_DVO_HWM_EN.
module mp_fifo_dat_vld_output #(
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int DEPTH          = 8,
  parameter int ENQ_WIDTH      = 2,
  parameter int DEQ_WIDTH      = 2,
  parameter int MUST_TAKEN_ALL = 1,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush_i,
  input  logic [ENQ_WIDTH-1:0]                     enqueue_vld_i,
  input  logic [ENQ_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  enqueue_payload_i,
  output logic [ENQ_WIDTH-1:0]                     enqueue_rdy_o,
  output logic [DEQ_WIDTH-1:0]                     dequeue_vld_o,
  output logic [DEQ_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  dequeue_payload_o,
  input  logic [DEQ_WIDTH-1:0]                     dequeue_rdy_i,
  output logic [DEPTH-1:0][PAYLOAD_WIDTH-1:0]      payload_dff_o,
  output logic [DEPTH-1:0]                         payload_vld_dff_o,
  output logic [CW-1:0]                            used_cnt_o,
  output logic [CW-1:0]                            avail_cnt_o
`ifdef MP_FIFO_DVO_HWM_EN
  ,
  output logic [CW-1:0]                            hwm_o
`endif
);

  localparam int PW                  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ENQ_C    = CW'(ENQ_WIDTH);

  logic [PAYLOAD_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]         vld_reg, vld_next;
  logic [PW-1:0]            head_reg, head_next, tail_reg, tail_next;
  logic [CW-1:0]            used_reg, used_next, avail;
  logic [ENQ_WIDTH-1:0]     enq_fire;
  logic [DEQ_WIDTH-1:0]     deq_fire;
  logic [CW-1:0]            n_enq, n_deq;
  logic [PW-1:0]            enq_idx [ENQ_WIDTH];
  logic [PW-1:0]            deq_idx [DEQ_WIDTH];

  // Modular add by compare-and-subtract so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [PW:0] off);
    logic [PW:0] s;
    s = {1'b0, p} + off;
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  assign avail       = DEPTH_C - used_reg;
  assign used_cnt_o  = used_reg;
  assign avail_cnt_o = avail;
  assign payload_vld_dff_o = vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_raw
      assign payload_dff_o[gi] = mem_reg[gi];
    end

    for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq
      assign enq_idx[gi] = wrap_add(tail_reg, (PW + 1)'(gi));
      if (MUST_TAKEN_ALL != 0) begin : g_all
        assign enqueue_rdy_o[gi] = (avail >= ENQ_C);
      end else begin : g_part
        assign enqueue_rdy_o[gi] = (avail > CW'(gi));
      end
      if (gi == 0) begin : g_first
        assign enq_fire[gi] = enqueue_vld_i[gi] & enqueue_rdy_o[gi];
      end else begin : g_rest
        assign enq_fire[gi] = enqueue_vld_i[gi] & enqueue_rdy_o[gi] & enq_fire[gi-1];
      end
    end

    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
      assign deq_idx[gi]           = wrap_add(head_reg, (PW + 1)'(gi));
      assign dequeue_vld_o[gi]     = (used_reg > CW'(gi));
      assign dequeue_payload_o[gi] = mem_reg[deq_idx[gi]];
      if (gi == 0) begin : g_first
        assign deq_fire[gi] = dequeue_vld_o[gi] & dequeue_rdy_i[gi];
      end else begin : g_rest
        assign deq_fire[gi] = dequeue_vld_o[gi] & dequeue_rdy_i[gi] & deq_fire[gi-1];
      end
    end
  endgenerate

  always_comb begin
    n_enq = '0;
    n_deq = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) n_enq = n_enq + CW'(enq_fire[i]);
    for (int i = 0; i < DEQ_WIDTH; i++) n_deq = n_deq + CW'(deq_fire[i]);
  end

  always_comb begin
    vld_next  = vld_reg;
    head_next = wrap_add(head_reg, (PW + 1)'(n_deq));
    tail_next = wrap_add(tail_reg, (PW + 1)'(n_enq));
    used_next = used_reg + n_enq - n_deq;
    for (int i = 0; i < DEQ_WIDTH; i++)
      if (deq_fire[i]) vld_next[deq_idx[i]] = 1'b0;
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (enq_fire[i]) vld_next[enq_idx[i]] = 1'b1;
    if (flush_i) begin
      vld_next  = '0;
      head_next = '0;
      tail_next = '0;
      used_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg  <= '0;
      head_reg <= '0;
      tail_reg <= '0;
      used_reg <= '0;
    end else begin
      vld_reg  <= vld_next;
      head_reg <= head_next;
      tail_reg <= tail_next;
      used_reg <= used_next;
    end
  end

  // Storage holds data only; it has no reset and a flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int i = 0; i < ENQ_WIDTH; i++)
        if (enq_fire[i]) mem_reg[enq_idx[i]] <= enqueue_payload_i[i];
    end
  end

`ifdef MP_FIFO_DVO_HWM_EN
  logic [CW-1:0] hwm_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_reg <= '0;
    else if (used_next > hwm_reg) hwm_reg <= used_next;
  end

  assign hwm_o = hwm_reg;
`endif

endmodule

// File: tb/tb_mp_fifo_dat_vld_output.sv
// Directed bench for mp_fifo_dat_vld_output: vector table plus fill/wrap/partial/flush/reset sequences.
// A second instance with MUST_TAKEN_ALL=0 shares the stimulus for the partial-space case.
module tb_mp_fifo_dat_vld_output;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush_i = 1'b0;
  logic [1:0] enqueue_vld_i = '0;
  logic [1:0][7:0] enqueue_payload_i = '0;
  logic [1:0] dequeue_rdy_i = '0;

  logic [1:0] enqueue_rdy_o, dequeue_vld_o;
  logic [1:0][7:0] dequeue_payload_o;
  logic [7:0][7:0] payload_dff_o;
  logic [7:0] payload_vld_dff_o;
  logic [3:0] used_cnt_o, avail_cnt_o;

  logic [1:0] enqueue_rdy_o0, dequeue_vld_o0;
  logic [1:0][7:0] dequeue_payload_o0;
  logic [7:0][7:0] payload_dff_o0;
  logic [7:0] payload_vld_dff_o0;
  logic [3:0] used_cnt_o0, avail_cnt_o0;
`ifdef MP_FIFO_DVO_HWM_EN
  logic [3:0] hwm_o, hwm_o0;
`endif

  always #5 clk = ~clk;

  mp_fifo_dat_vld_output #(.PAYLOAD_WIDTH(8), .DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .MUST_TAKEN_ALL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enqueue_vld_i(enqueue_vld_i), .enqueue_payload_i(enqueue_payload_i), .enqueue_rdy_o(enqueue_rdy_o),
    .dequeue_vld_o(dequeue_vld_o), .dequeue_payload_o(dequeue_payload_o), .dequeue_rdy_i(dequeue_rdy_i),
    .payload_dff_o(payload_dff_o), .payload_vld_dff_o(payload_vld_dff_o),
    .used_cnt_o(used_cnt_o), .avail_cnt_o(avail_cnt_o)
`ifdef MP_FIFO_DVO_HWM_EN
    , .hwm_o(hwm_o)
`endif
  );

  mp_fifo_dat_vld_output #(.PAYLOAD_WIDTH(8), .DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .MUST_TAKEN_ALL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enqueue_vld_i(enqueue_vld_i), .enqueue_payload_i(enqueue_payload_i), .enqueue_rdy_o(enqueue_rdy_o0),
    .dequeue_vld_o(dequeue_vld_o0), .dequeue_payload_o(dequeue_payload_o0), .dequeue_rdy_i(dequeue_rdy_i),
    .payload_dff_o(payload_dff_o0), .payload_vld_dff_o(payload_vld_dff_o0),
    .used_cnt_o(used_cnt_o0), .avail_cnt_o(avail_cnt_o0)
`ifdef MP_FIFO_DVO_HWM_EN
    , .hwm_o(hwm_o0)
`endif
  );

  typedef struct {
    logic [1:0] ev;
    logic [7:0] p0, p1;
    logic [1:0] dr;
    logic       fl;
    logic [3:0] used;
    logic [1:0] erdy;
    logic [1:0] dvld;
    logic [7:0] d0, d1;
    logic [7:0] vdff;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then sample 1 ns after the rising edge.
  task automatic cyc(input logic [1:0] ev, input logic [7:0] p0, input logic [7:0] p1,
                     input logic [1:0] dr, input logic fl);
    @(negedge clk);
    enqueue_vld_i = ev;
    enqueue_payload_i[0] = p0;
    enqueue_payload_i[1] = p1;
    dequeue_rdy_i = dr;
    flush_i = fl;
    @(posedge clk);
    #1;
    $display("cycle ev=%b p=%h/%h dr=%b fl=%b -> used=%0d rdy=%b dvld=%b vdff=%h",
             ev, p0, p1, dr, fl, used_cnt_o, enqueue_rdy_o, dequeue_vld_o, payload_vld_dff_o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enqueue_vld_i = '0;
    dequeue_rdy_i = '0;
    flush_i = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_used"}, 32'(used_cnt_o), 32'd0);
    chk({tag, "_avail"}, 32'(avail_cnt_o), 32'd8);
    chk({tag, "_vdff"}, 32'(payload_vld_dff_o), 32'h00);
    chk({tag, "_dvld"}, 32'(dequeue_vld_o), 32'h0);
    chk({tag, "_erdy"}, 32'(enqueue_rdy_o), 32'h3);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{2'b11, 8'h10, 8'h11, 2'b00, 1'b0, 4'd2, 2'b11, 2'b11, 8'h10, 8'h11, 8'h03};
    vecs[1] = '{2'b11, 8'h12, 8'h13, 2'b00, 1'b0, 4'd4, 2'b11, 2'b11, 8'h10, 8'h11, 8'h0F};
    vecs[2] = '{2'b11, 8'h14, 8'h15, 2'b00, 1'b0, 4'd6, 2'b11, 2'b11, 8'h10, 8'h11, 8'h3F};
    vecs[3] = '{2'b11, 8'h16, 8'h17, 2'b00, 1'b0, 4'd8, 2'b00, 2'b11, 8'h10, 8'h11, 8'hFF};
    vecs[4] = '{2'b11, 8'hEE, 8'hEF, 2'b11, 1'b0, 4'd6, 2'b11, 2'b11, 8'h12, 8'h13, 8'hFC};
    vecs[5] = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b0, 4'd6, 2'b11, 2'b11, 8'h12, 8'h13, 8'hFC};
    vecs[6] = '{2'b00, 8'h00, 8'h00, 2'b01, 1'b0, 4'd5, 2'b11, 2'b11, 8'h13, 8'h14, 8'hF8};
    vecs[7] = '{2'b11, 8'h20, 8'h21, 2'b11, 1'b0, 4'd5, 2'b11, 2'b11, 8'h15, 8'h16, 8'hE3};
    vecs[8] = '{2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 4'd3, 2'b11, 2'b11, 8'h17, 8'h20, 8'h83};
    vecs[9] = '{2'b11, 8'h30, 8'h31, 2'b11, 1'b0, 4'd3, 2'b11, 2'b11, 8'h21, 8'h30, 8'h0E};

    // Asynchronous reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset_state("rst0");
    #4 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].ev, vecs[i].p0, vecs[i].p1, vecs[i].dr, vecs[i].fl);
      chk($sformatf("v%0d_used", i), 32'(used_cnt_o), 32'(vecs[i].used));
      chk($sformatf("v%0d_avail", i), 32'(avail_cnt_o), 32'(4'd8 - vecs[i].used));
      chk($sformatf("v%0d_erdy", i), 32'(enqueue_rdy_o), 32'(vecs[i].erdy));
      chk($sformatf("v%0d_dvld", i), 32'(dequeue_vld_o), 32'(vecs[i].dvld));
      chk($sformatf("v%0d_d0", i), 32'(dequeue_payload_o[0]), 32'(vecs[i].d0));
      chk($sformatf("v%0d_d1", i), 32'(dequeue_payload_o[1]), 32'(vecs[i].d1));
      chk($sformatf("v%0d_vdff", i), 32'(payload_vld_dff_o), 32'(vecs[i].vdff));
    end

    // Wrap: head/tail both at 6, then two enqueues straddle the end of storage.
    do_reset();
    cyc(2'b11, 8'h00, 8'h01, 2'b00, 1'b0);
    cyc(2'b11, 8'h02, 8'h03, 2'b00, 1'b0);
    cyc(2'b11, 8'h04, 8'h05, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    chk("wrap_empty_used", 32'(used_cnt_o), 32'd0);
    chk("wrap_empty_dvld", 32'(dequeue_vld_o), 32'h0);
    cyc(2'b11, 8'hA0, 8'hA1, 2'b00, 1'b0);
    chk("wrap_e6", 32'(payload_dff_o[6]), 32'hA0);
    chk("wrap_e7", 32'(payload_dff_o[7]), 32'hA1);
    cyc(2'b11, 8'hB0, 8'hB1, 2'b00, 1'b0);
    chk("wrap_e0", 32'(payload_dff_o[0]), 32'hB0);
    chk("wrap_e1", 32'(payload_dff_o[1]), 32'hB1);
    chk("wrap_vdff", 32'(payload_vld_dff_o), 32'hC3);
    chk("wrap_d0a", 32'(dequeue_payload_o[0]), 32'hA0);
    chk("wrap_d1a", 32'(dequeue_payload_o[1]), 32'hA1);
    cyc(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    chk("wrap_d0b", 32'(dequeue_payload_o[0]), 32'hB0);
    chk("wrap_d1b", 32'(dequeue_payload_o[1]), 32'hB1);
    cyc(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    chk("wrap_final_used", 32'(used_cnt_o), 32'd0);

    // Partial space at used=7: all-or-nothing instance refuses, per-lane instance takes lane 0.
    do_reset();
    cyc(2'b11, 8'h10, 8'h11, 2'b00, 1'b0);
    cyc(2'b11, 8'h12, 8'h13, 2'b00, 1'b0);
    cyc(2'b11, 8'h14, 8'h15, 2'b00, 1'b0);
    cyc(2'b01, 8'h16, 8'h00, 2'b00, 1'b0);
    chk("part_used7", 32'(used_cnt_o), 32'd7);
    chk("part_erdy_all", 32'(enqueue_rdy_o), 32'h0);
    chk("part_erdy_lane", 32'(enqueue_rdy_o0), 32'h1);
    cyc(2'b11, 8'hE0, 8'hE1, 2'b00, 1'b0);
    chk("part_used_all", 32'(used_cnt_o), 32'd7);
    chk("part_used_lane", 32'(used_cnt_o0), 32'd8);
    chk("part_e7_lane", 32'(payload_dff_o0[7]), 32'hE0);
    chk("part_erdy_lane_full", 32'(enqueue_rdy_o0), 32'h0);

    // Flush from used=5 discards same-cycle traffic and leaves storage alone.
    do_reset();
    cyc(2'b11, 8'h50, 8'h51, 2'b00, 1'b0);
    cyc(2'b11, 8'h52, 8'h53, 2'b00, 1'b0);
    cyc(2'b01, 8'h54, 8'h00, 2'b00, 1'b0);
    chk("fl_used5", 32'(used_cnt_o), 32'd5);
    cyc(2'b11, 8'h60, 8'h61, 2'b11, 1'b1);
    chk("fl_used", 32'(used_cnt_o), 32'd0);
    chk("fl_avail", 32'(avail_cnt_o), 32'd8);
    chk("fl_vdff", 32'(payload_vld_dff_o), 32'h00);
    chk("fl_dvld", 32'(dequeue_vld_o), 32'h0);
    chk("fl_e5_kept", 32'(payload_dff_o[5]), 32'h15);
    chk("fl_e0_kept", 32'(payload_dff_o[0]), 32'h50);
`ifdef MP_FIFO_DVO_HWM_EN
    chk("fl_hwm", 32'(hwm_o), 32'd5);
`endif
    cyc(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    flush_i = 1'b0;
    cyc(2'b11, 8'h70, 8'h71, 2'b00, 1'b0);
    cyc(2'b11, 8'h72, 8'h73, 2'b00, 1'b0);
    cyc(2'b01, 8'h74, 8'h00, 2'b00, 1'b0);
    chk("refill_used5", 32'(used_cnt_o), 32'd5);
    chk("refill_d0", 32'(dequeue_payload_o[0]), 32'h70);

    // Reset asserted mid-cycle must clear outputs before the next edge.
    @(negedge clk);
    enqueue_vld_i = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("rst_mid");
`ifdef MP_FIFO_DVO_HWM_EN
    chk("rst_mid_hwm", 32'(hwm_o), 32'd0);
`endif
    #1 rst_n = 1'b1;
    cyc(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    chk("post_rst_used", 32'(used_cnt_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_fifo_dat_vld_output.md
MP_FIFO_DAT_VLD_OUTPUT -- requirements
Module: mp_fifo_dat_vld_output

Interface
REQ-001 Parameters SHALL be:
- PAYLOAD_WIDTH, default 32, bits per entry.
- DEPTH, default 8, entry count; SHALL be >= max(ENQ_WIDTH, DEQ_WIDTH); non-power-of-two SHALL be supported.
- ENQ_WIDTH, default 2, enqueue lanes.
- DEQ_WIDTH, default 2, dequeue lanes.
- MUST_TAKEN_ALL, default 1, all-or-nothing enqueue readiness.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush.
- enqueue_vld_i  in  ENQ_WIDTH  per-lane enqueue valid.
- enqueue_payload_i  in  ENQ_WIDTH x PAYLOAD_WIDTH  per-lane payload.
- enqueue_rdy_o  out  ENQ_WIDTH  per-lane ready.
- dequeue_vld_o  out  DEQ_WIDTH  per-lane valid.
- dequeue_payload_o  out  DEQ_WIDTH x PAYLOAD_WIDTH  per-lane head data.
- dequeue_rdy_i  in  DEQ_WIDTH  per-lane consumer ready.
- payload_dff_o  out  DEPTH x PAYLOAD_WIDTH  raw storage array.
- payload_vld_dff_o  out  DEPTH  per-entry occupied flag.
- used_cnt_o  out  clog2(DEPTH+1)  occupied entries.
- avail_cnt_o  out  clog2(DEPTH+1)  free entries; equals DEPTH - used_cnt_o.

Function
REQ-003 Lane firing SHALL be prefix-ordered: enqueue lane i fires iff enqueue_vld_i[i] and enqueue_rdy_o[i] are high and every lane below i fires; dequeue lanes follow the same rule with dequeue_vld_o and dequeue_rdy_i.
REQ-004 With MUST_TAKEN_ALL=1, every bit of enqueue_rdy_o SHALL equal (avail_cnt >= ENQ_WIDTH); with MUST_TAKEN_ALL=0, enqueue_rdy_o[i] SHALL equal (avail_cnt > i).
REQ-005 Ready SHALL derive only from the registered avail_cnt; a same-cycle dequeue SHALL NOT free space for a same-cycle enqueue.
REQ-006 dequeue_vld_o[i] SHALL equal (used_cnt > i), and dequeue_payload_o[i] SHALL equal the storage entry at (head + i) mod DEPTH; both are combinational from registers.
REQ-007 Fired enqueue lane i SHALL write the storage entry at (tail + i) mod DEPTH and set its vld flag on the next edge.
REQ-008 Fired dequeue lane i SHALL clear the vld flag of the entry at (head + i) mod DEPTH.
REQ-009 Pointer and count updates on the next edge SHALL be: head += n_deq, tail += n_enq (both mod DEPTH, explicit wrap compare, no power-of-two masking), used += n_enq - n_deq.
REQ-010 Simultaneous enqueue and dequeue SHALL be supported in the same cycle; by REQ-005 they never target the same entry.
REQ-011 Full (used=DEPTH) SHALL give enqueue_rdy_o=0; empty (used=0) SHALL give dequeue_vld_o=0.
REQ-012 flush_i=1 SHALL have priority over enqueue and dequeue: next edge head=tail=used=0 and payload_vld_dff_o=0; enqueue/dequeue fires in that cycle are discarded; storage data is untouched.
REQ-013 Storage data SHALL be written only by enqueue and SHALL NOT be reset.

Reset
REQ-014 While rst_n=0, without waiting for clk: head=tail=0, used_cnt_o=0, avail_cnt_o=DEPTH, payload_vld_dff_o=0, dequeue_vld_o=0, and enqueue_rdy_o all ones.
REQ-015 Reset deassertion SHALL be synchronised externally; the first update occurs on the first clk edge after rst_n=1.

Configuration
REQ-016 When macro MP_FIFO_DVO_HWM_EN is defined, the block SHALL add output hwm_o [clog2(DEPTH+1)], the maximum used_cnt reached since reset, updated each edge to max(hwm, next used); reset value is 0, and flush SHALL NOT clear it.
REQ-017 When MP_FIFO_DVO_HWM_EN is undefined, the hwm_o port and its register SHALL be absent, with all other behaviour unchanged.

Verification (DEPTH=8, ENQ_WIDTH=2, DEQ_WIDTH=2, PAYLOAD_WIDTH=8)
REQ-018 Fill: enqueue 2/cycle payloads 0x10..0x17 over 4 cycles, dequeue_rdy_i=0 -> used=8, enqueue_rdy_o=2'b00, payload_vld_dff_o=8'hFF, dequeue_payload_o lanes 0/1 = 0x10/0x11.
REQ-019 Wrap: 6 enqueues then 6 dequeues, then enqueue 0xA0,0xA1 then 0xB0,0xB1 -> 0xA0/0xA1 land in entries 6/7 and 0xB0/0xB1 in entries 0/1; dequeue order is A0,A1,B0,B1.
REQ-020 Partial space at used=7: MUST_TAKEN_ALL=1 with enqueue_vld_i=2'b11 -> enqueue_rdy_o=2'b00 and nothing enqueued; MUST_TAKEN_ALL=0 -> enqueue_rdy_o=2'b01 and only lane 0 fires, giving used=8.
REQ-021 Concurrency: at used=3, enqueue 2 and dequeue 2 in one cycle -> used stays 3, head and tail each advance by 2; dequeue_rdy_i=2'b10 -> no dequeue (prefix rule).
REQ-022 Flush/reset: flush_i=1 with used=5 and enqueue_vld_i=2'b11 -> next cycle used=0, payload_vld_dff_o=0 and inputs discarded; rst_n=0 mid-cycle with used=5 -> outputs reach REQ-014 values before the next edge; with MP_FIFO_DVO_HWM_EN defined, hwm_o=5 persists after the flush.
